// File: rtl/inst_fetch_buffer_pkg.sv
// Shared fetch-path constants, bus widths and the {pc, inst} FIFO entry type.
// Imported by the fetch buffer, its FIFO and its interface.
package inst_fetch_buffer_pkg;

  localparam int INST_ADDR_W = 32;
  localparam int INST_W      = 32;

  localparam logic [INST_ADDR_W-1:0] RESET_PC_DEF = 32'h0000_0000;
  localparam logic [INST_W-1:0]      ZERO_WORD    = 32'h0000_0000;
  localparam logic [INST_ADDR_W-1:0] PC_STEP      = 32'd4;

  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic RST_ENABLE   = 1'b1;

  typedef struct packed {
    logic [INST_ADDR_W-1:0] pc;
    logic [INST_W-1:0]      inst;
  } fetch_entry_t;

  localparam int ENTRY_W = $bits(fetch_entry_t);

  function automatic logic [INST_ADDR_W-1:0] align_word(input logic [INST_ADDR_W-1:0] addr);
    return addr & ~32'h3;
  endfunction

endpackage

// File: rtl/inst_fetch_buffer_if.sv
// IF-stage and instruction-ROM signals of the fetch buffer; master = fetch buffer side.
interface inst_fetch_buffer_if;
  import inst_fetch_buffer_pkg::*;

  logic                   stall;
  logic                   flush;
  logic [INST_ADDR_W-1:0] new_pc;
  logic                   rom_ce;
  logic [INST_ADDR_W-1:0] rom_addr;
  logic [INST_W-1:0]      rom_inst;
  logic                   if_valid;
  logic [INST_ADDR_W-1:0] if_pc;
  logic [INST_W-1:0]      if_inst;

  modport master (
    input  stall, flush, new_pc, rom_inst,
    output rom_ce, rom_addr, if_valid, if_pc, if_inst
  );

  modport slave (
    output stall, flush, new_pc, rom_inst,
    input  rom_ce, rom_addr, if_valid, if_pc, if_inst
  );

endinterface

// File: rtl/inst_fetch_buffer_fetch_fifo.sv
// Fetch FIFO: write-then-visible next cycle, combinational head read; clear wins over push/pop.
// Caller must not push when full without a same-cycle pop, nor pop when empty.
module inst_fetch_buffer_fetch_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic                       clear,
  input  logic [WIDTH-1:0]           din,
  output logic [WIDTH-1:0]           dout,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       empty,
  output logic                       full
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  always_comb begin
    mem_d    = mem_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (clear) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        mem_d[wr_ptr_q] = din;
        wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      // Power-of-two DEPTH lets the pointers wrap by plain overflow.
      if (push && !pop) begin
        count_d = count_q + CNT_W'(1);
      end else if (pop && !push) begin
        count_d = count_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  assign dout  = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

endmodule

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch sequencer: ROM word at rom_addr is enqueued on the closing edge, visible to IF next cycle.
// Stall fills the FIFO then halts fetch; flush empties it and refetches from new_pc the following cycle.
module inst_fetch_buffer
  import inst_fetch_buffer_pkg::*;
#(
  parameter int                     DEPTH    = 4,
  parameter logic [INST_ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  inst_fetch_buffer_if.master  bus
);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [INST_ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic                   rom_ce_c;
  logic                   push;
  logic                   pop;
  logic                   if_valid_c;
  fetch_entry_t           wr_entry;
  fetch_entry_t           head;
  logic [CNT_W-1:0]       fifo_count;
  logic                   fifo_empty;
  logic                   fifo_full;

  assign if_valid_c = (fifo_count != '0);
  assign pop        = !fifo_empty && !bus.stall && !bus.flush;

  // A pop frees the slot being written, so a full FIFO still fetches when IF drains it.
  always_comb begin
    rom_ce_c = CHIP_DISABLE;
    if (rst != RST_ENABLE && !bus.flush && (!fifo_full || pop)) begin
      rom_ce_c = CHIP_ENABLE;
    end
  end

  assign push          = rom_ce_c;
  assign wr_entry.pc   = fetch_pc_q;
  assign wr_entry.inst = bus.rom_inst;

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    if (bus.flush) begin
      fetch_pc_d = align_word(bus.new_pc);
    end else if (push) begin
      fetch_pc_d = fetch_pc_q + PC_STEP;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst == RST_ENABLE) begin
      fetch_pc_q <= RESET_PC;
    end else begin
      fetch_pc_q <= fetch_pc_d;
    end
  end

  inst_fetch_buffer_fetch_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .clear (bus.flush),
    .din   (wr_entry),
    .dout  (head),
    .count (fifo_count),
    .empty (fifo_empty),
    .full  (fifo_full)
  );

  assign bus.rom_ce   = rom_ce_c;
  assign bus.rom_addr = fetch_pc_q;
  assign bus.if_valid = if_valid_c;
  assign bus.if_pc    = if_valid_c ? head.pc   : ZERO_WORD;
  assign bus.if_inst  = if_valid_c ? head.inst : ZERO_WORD;

endmodule
